// File: rtl/mc_ctrl_if.sv
// Bundle between the multi-cycle control unit and the datapath: IR fields and
// flags in, mux selects / write enables / memory strobes out.
interface mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_we;
  logic       iord;
  logic       mem_rd;
  logic       mem_wr;
  logic       ir_we;
  logic       reg_we;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_op;
  logic [2:0] aluc;
  logic [1:0] pc_source;
  logic       illegal;
  logic [3:0] state;

  // Handshake: a memory strobe (mem_rd/mem_wr) stays asserted with a stable
  // iord until the cycle mem_ready is high; that cycle completes the access.
  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_we, iord, mem_rd, mem_wr, ir_we, reg_we, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, ext_op, aluc, pc_source, illegal, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_we, iord, mem_rd, mem_wr, ir_we, reg_we, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, ext_op, aluc, pc_source, illegal, state
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset controller: state register, next-state logic and a
// Moore-style output decode (mem_ready/zero/opcode folded in where needed).
module mc_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  mc_ctrl_if.master   bus
);
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_I_EXEC    = 4'd9,
    S_I_WB      = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_ERROR     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;

  state_t     cur, nxt;
  logic [2:0] r_aluc;
  logic       r_legal;
  logic [2:0] i_aluc;
  logic       i_zext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= S_IDLE;
    else        cur <= nxt;
  end

  always_comb begin
    r_aluc  = 3'b000;
    r_legal = 1'b1;
    case (bus.funct)
      6'b100000, 6'b100001: r_aluc = 3'b000;
      6'b100010, 6'b100011: r_aluc = 3'b001;
      6'b100100:            r_aluc = 3'b010;
      6'b100101:            r_aluc = 3'b011;
      6'b100110:            r_aluc = 3'b100;
      6'b100111:            r_aluc = 3'b101;
      6'b101011:            r_aluc = 3'b110;
      6'b101010:            r_aluc = 3'b111;
      default:              r_legal = 1'b0;
    endcase
  end

  // Logical immediates are zero-extended; arithmetic and compares sign-extend.
  always_comb begin
    i_aluc = 3'b000;
    i_zext = 1'b0;
    case (bus.opcode)
      OP_ANDI:  begin i_aluc = 3'b010; i_zext = 1'b1; end
      OP_ORI:   begin i_aluc = 3'b011; i_zext = 1'b1; end
      OP_XORI:  begin i_aluc = 3'b100; i_zext = 1'b1; end
      OP_SLTIU: i_aluc = 3'b110;
      OP_SLTI:  i_aluc = 3'b111;
      default:  i_aluc = 3'b000;
    endcase
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:      nxt = S_FETCH;
      S_FETCH:     if (bus.mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:        nxt = S_R_EXEC;
          OP_LW, OP_SW:    nxt = S_MEM_ADDR;
          OP_BEQ, OP_BNE:  nxt = S_BRANCH;
          OP_J:            nxt = S_JUMP;
          OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU:
                           nxt = S_I_EXEC;
          default:         nxt = S_ERROR;
        endcase
      end
      S_MEM_ADDR:  nxt = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (bus.mem_ready) nxt = S_MEM_WB;
      S_MEM_WB:    nxt = S_FETCH;
      S_MEM_WRITE: if (bus.mem_ready) nxt = S_FETCH;
      S_R_EXEC:    nxt = r_legal ? S_R_WB : S_ERROR;
      S_R_WB:      nxt = S_FETCH;
      S_I_EXEC:    nxt = S_I_WB;
      S_I_WB:      nxt = S_FETCH;
      S_BRANCH:    nxt = S_FETCH;
      S_JUMP:      nxt = S_FETCH;
      S_ERROR:     nxt = S_ERROR;
      default:     nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.pc_we      = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.ir_we      = 1'b0;
    bus.reg_we     = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.ext_op     = 1'b0;
    bus.aluc       = 3'b000;
    bus.pc_source  = 2'b00;
    bus.illegal    = 1'b0;
    case (cur)
      S_FETCH: begin
        bus.mem_rd    = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_we     = bus.mem_ready;
        bus.pc_we     = bus.mem_ready;
      end
      S_DECODE: begin
        bus.alu_src_b = 2'b11;
        bus.ext_op    = 1'b1;
      end
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.ext_op    = 1'b1;
      end
      S_MEM_READ: begin
        bus.mem_rd = 1'b1;
        bus.iord   = 1'b1;
      end
      S_MEM_WB: begin
        bus.reg_we     = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        bus.mem_wr = 1'b1;
        bus.iord   = 1'b1;
      end
      S_R_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.aluc      = r_aluc;
      end
      S_R_WB: begin
        bus.reg_we  = 1'b1;
        bus.reg_dst = 1'b1;
      end
      S_I_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.ext_op    = ~i_zext;
        bus.aluc      = i_aluc;
      end
      S_I_WB:   bus.reg_we = 1'b1;
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.aluc      = 3'b001;
        bus.pc_source = 2'b01;
        bus.pc_we     = bus.zero ^ (bus.opcode == OP_BNE);
      end
      S_JUMP: begin
        bus.pc_source = 2'b10;
        bus.pc_we     = 1'b1;
      end
      S_ERROR:  bus.illegal = 1'b1;
      default:  bus.illegal = 1'b0;
    endcase
  end

  assign bus.state = cur;
endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: table-driven instruction vectors, hand sequences for
// memory waits / error / async reset, and randomized instructions vs a model.
module tb_mc_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mc_ctrl_if bus();
  mc_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cycles, ir_we, pc_we, reg_we, mem_rd, mem_wr;
    int aluc, ext, dst, m2r, err, viol;
  } stats_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int wf, wm, cycles, pc, regw, rd, wr, aluc, ext, dst, m2r, err;
  } vec_t;

  vec_t       vt[18];
  int         st_q[$];
  logic [5:0] legal_ops[15];
  logic [5:0] legal_fn[10];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int outs_word();
    return {10'd0, bus.pc_we, bus.iord, bus.mem_rd, bus.mem_wr, bus.ir_we,
            bus.reg_we, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
            bus.alu_src_b, bus.ext_op, bus.aluc, bus.pc_source, bus.illegal,
            bus.state};
  endfunction

  function automatic int strobes();
    return int'({bus.pc_we, bus.ir_we, bus.reg_we, bus.mem_rd, bus.mem_wr});
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_outs", outs_word(), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_hold", outs_word(), 0);
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", int'(bus.state), 0);
    @(posedge clk); #1;
    chk("first_fetch", int'(bus.state), 1);
  endtask

  // Runs one instruction from the first FETCH cycle until the next FETCH (or
  // ERROR). mem_ready follows a planned wait pattern; random where ignored.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int wf, input int wm,
                           output stats_t s);
    bit is_mem;
    bit seen_other;
    bit done;
    int k;
    logic mr;
    s = '{0, 0, 0, 0, 0, 0, -1, -1, -1, -1, 0, 0};
    is_mem = (op == 6'h23) || (op == 6'h2b);
    seen_other = 0;
    done = 0;
    k = 0;
    st_q.delete();
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = z;
    while (!done && k < 40) begin
      if (k < wf)                                   mr = 1'b0;
      else if (k == wf)                             mr = 1'b1;
      else if (is_mem && k >= wf + 3 && k < wf + 3 + wm) mr = 1'b0;
      else if (is_mem && k == wf + 3 + wm)          mr = 1'b1;
      else                                          mr = 1'($urandom_range(0, 1));
      bus.mem_ready = mr;
      @(negedge clk);
      st_q.push_back(int'(bus.state));
      s.ir_we  += int'(bus.ir_we);
      s.pc_we  += int'(bus.pc_we);
      s.reg_we += int'(bus.reg_we);
      s.mem_rd += int'(bus.mem_rd);
      s.mem_wr += int'(bus.mem_wr);
      if ((bus.mem_rd && bus.mem_wr) || (bus.ir_we && bus.state != 4'd1) ||
          (bus.reg_we && bus.pc_we))
        s.viol++;
      if (bus.state == 4'd7 || bus.state == 4'd9 || bus.state == 4'd11) begin
        s.aluc = int'(bus.aluc);
        s.ext  = int'(bus.ext_op);
      end
      if (bus.reg_we) begin
        s.dst = int'(bus.reg_dst);
        s.m2r = int'(bus.mem_to_reg);
      end
      if (bus.state == 4'd13) begin
        s.err = 1;
        done = 1;
      end else begin
        if (bus.state != 4'd1) seen_other = 1;
        @(posedge clk); #1;
        k++;
        if (seen_other && bus.state == 4'd1) begin
          done = 1;
          s.cycles = k;
        end
      end
    end
    if (!done) begin
      chk("instr_timeout", 0, 1);
      s.cycles = -1;
    end
  endtask

  task automatic cmp(input string tag, input stats_t g, input stats_t e);
    chk({tag, ".err"}, g.err, e.err);
    if (e.err == 0) begin
      chk({tag, ".cycles"}, g.cycles, e.cycles);
      chk({tag, ".aluc"}, g.aluc, e.aluc);
      chk({tag, ".ext"}, g.ext, e.ext);
    end
    chk({tag, ".ir_we"}, g.ir_we, e.ir_we);
    chk({tag, ".pc_we"}, g.pc_we, e.pc_we);
    chk({tag, ".reg_we"}, g.reg_we, e.reg_we);
    chk({tag, ".mem_rd"}, g.mem_rd, e.mem_rd);
    chk({tag, ".mem_wr"}, g.mem_wr, e.mem_wr);
    chk({tag, ".dst"}, g.dst, e.dst);
    chk({tag, ".m2r"}, g.m2r, e.m2r);
    chk({tag, ".viol"}, g.viol, 0);
  endtask

  task automatic err_hold(input string tag);
    int bad = 0;
    for (int i = 0; i < 6; i++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (strobes() != 0 || !bus.illegal || bus.state != 4'd13) bad++;
    end
    chk({tag, ".error_hold"}, bad, 0);
  endtask

  // Reference: instruction class determines the visit sequence length and the
  // number of enable pulses; waits add one cycle each.
  function automatic stats_t model(input logic [5:0] op, input logic [5:0] fn,
                                   input logic z, input int wf, input int wm);
    stats_t e;
    int ra;
    bit rl;
    e = '{0, 1, 1, 0, wf + 1, 0, -1, -1, -1, -1, 0, 0};
    rl = 1;
    case (fn)
      6'h20, 6'h21: ra = 0;
      6'h22, 6'h23: ra = 1;
      6'h24: ra = 2;
      6'h25: ra = 3;
      6'h26: ra = 4;
      6'h27: ra = 5;
      6'h2b: ra = 6;
      6'h2a: ra = 7;
      default: begin ra = 0; rl = 0; end
    endcase
    case (op)
      6'h00: if (rl) begin
               e.cycles = 4 + wf; e.reg_we = 1; e.dst = 1; e.m2r = 0;
               e.aluc = ra; e.ext = 0;
             end else e.err = 1;
      6'h23: begin
               e.cycles = 5 + wf + wm; e.reg_we = 1; e.dst = 0; e.m2r = 1;
               e.mem_rd += wm + 1;
             end
      6'h2b: begin e.cycles = 4 + wf + wm; e.mem_wr = wm + 1; end
      6'h04, 6'h05: begin
               e.cycles = 3 + wf; e.aluc = 1; e.ext = 0;
               e.pc_we += int'(z ^ (op == 6'h05));
             end
      6'h02: begin e.cycles = 3 + wf; e.pc_we = 2; end
      6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h0a, 6'h0b: begin
               e.cycles = 4 + wf; e.reg_we = 1; e.dst = 0; e.m2r = 0;
               case (op)
                 6'h0c: begin e.aluc = 2; e.ext = 0; end
                 6'h0d: begin e.aluc = 3; e.ext = 0; end
                 6'h0e: begin e.aluc = 4; e.ext = 0; end
                 6'h0b: begin e.aluc = 6; e.ext = 1; end
                 6'h0a: begin e.aluc = 7; e.ext = 1; end
                 default: begin e.aluc = 0; e.ext = 1; end
               endcase
             end
      default: e.err = 1;
    endcase
    return e;
  endfunction

  initial begin
    stats_t g, e;
    bus.opcode = '0;
    bus.funct = '0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    legal_ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h08, 6'h09,
                  6'h0c, 6'h0d, 6'h0e, 6'h0a, 6'h0b, 6'h00, 6'h23};
    legal_fn = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                 6'h2b, 6'h2a};
    //          op     fn     z     wf wm cyc pc reg rd wr aluc ext dst m2r err
    vt[0]  = '{6'h00, 6'h20, 1'b0, 0, 0, 4,  1, 1,  1, 0, 0,  0,  1,  0,  0};
    vt[1]  = '{6'h00, 6'h22, 1'b0, 1, 0, 5,  1, 1,  2, 0, 1,  0,  1,  0,  0};
    vt[2]  = '{6'h00, 6'h2a, 1'b0, 0, 0, 4,  1, 1,  1, 0, 7,  0,  1,  0,  0};
    vt[3]  = '{6'h00, 6'h2b, 1'b1, 0, 0, 4,  1, 1,  1, 0, 6,  0,  1,  0,  0};
    vt[4]  = '{6'h00, 6'h27, 1'b0, 2, 0, 6,  1, 1,  3, 0, 5,  0,  1,  0,  0};
    vt[5]  = '{6'h23, 6'h00, 1'b0, 2, 3, 10, 1, 1,  7, 0, -1, -1, 0,  1,  0};
    vt[6]  = '{6'h2b, 6'h00, 1'b0, 0, 2, 6,  1, 0,  1, 3, -1, -1, -1, -1, 0};
    vt[7]  = '{6'h04, 6'h00, 1'b1, 0, 0, 3,  2, 0,  1, 0, 1,  0,  -1, -1, 0};
    vt[8]  = '{6'h05, 6'h00, 1'b1, 0, 0, 3,  1, 0,  1, 0, 1,  0,  -1, -1, 0};
    vt[9]  = '{6'h04, 6'h00, 1'b0, 0, 0, 3,  1, 0,  1, 0, 1,  0,  -1, -1, 0};
    vt[10] = '{6'h05, 6'h00, 1'b0, 0, 0, 3,  2, 0,  1, 0, 1,  0,  -1, -1, 0};
    vt[11] = '{6'h02, 6'h00, 1'b0, 0, 0, 3,  2, 0,  1, 0, -1, -1, -1, -1, 0};
    vt[12] = '{6'h0d, 6'h00, 1'b0, 0, 0, 4,  1, 1,  1, 0, 3,  0,  0,  0,  0};
    vt[13] = '{6'h0a, 6'h00, 1'b0, 0, 0, 4,  1, 1,  1, 0, 7,  1,  0,  0,  0};
    vt[14] = '{6'h0e, 6'h00, 1'b0, 3, 0, 7,  1, 1,  4, 0, 4,  0,  0,  0,  0};
    vt[15] = '{6'h09, 6'h00, 1'b0, 1, 0, 5,  1, 1,  2, 0, 0,  1,  0,  0,  0};
    vt[16] = '{6'h3f, 6'h00, 1'b0, 0, 0, 0,  1, 0,  1, 0, -1, -1, -1, -1, 1};
    vt[17] = '{6'h00, 6'h00, 1'b0, 0, 0, 0,  1, 0,  1, 0, -1, -1, -1, -1, 1};

    do_reset();
    for (int i = 0; i < 18; i++) begin
      e = '{vt[i].cycles, 1, vt[i].pc, vt[i].regw, vt[i].rd, vt[i].wr,
            vt[i].aluc, vt[i].ext, vt[i].dst, vt[i].m2r, vt[i].err, 0};
      run_instr(vt[i].op, vt[i].fn, vt[i].z, vt[i].wf, vt[i].wm, g);
      cmp($sformatf("vec%0d", i), g, e);
      if (i == 0) begin
        chk("add_states_len", st_q.size(), 4);
        if (st_q.size() == 4) begin
          chk("add_state0", st_q[0], 1);
          chk("add_state1", st_q[1], 2);
          chk("add_state2", st_q[2], 7);
          chk("add_state3", st_q[3], 8);
        end
      end
      if (g.err != 0) begin
        chk($sformatf("vec%0d.illegal", i), int'(bus.illegal), 1);
        err_hold($sformatf("vec%0d", i));
        do_reset();
      end else if (g.cycles < 0) begin
        do_reset();
      end
    end

    // Store stalled in MEM_WRITE, then reset asserted between clock edges.
    bus.opcode = 6'h2b;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("sw_wait_state", int'(bus.state), 6);
    chk("sw_wait_mem_wr", int'(bus.mem_wr), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("sw_wait_hold", int'({bus.mem_wr, bus.iord}), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_wr", int'(bus.mem_wr), 0);
    chk("async_rst_outs", outs_word(), 0);
    do_reset();

    for (int i = 0; i < 150; i++) begin
      logic [5:0] op, fn;
      logic z;
      int wf, wm;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 14)];
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 9)];
      z  = 1'($urandom_range(0, 1));
      wf = $urandom_range(0, 3);
      wm = $urandom_range(0, 3);
      e = model(op, fn, z, wf, wm);
      run_instr(op, fn, z, wf, wm, g);
      cmp($sformatf("rand%0d", i), g, e);
      if (g.err != 0 || g.cycles < 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
